// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU sequencer.
//   state_t      - sequencer FSM states (IDLE, SHIFT, DONE)
//   shift_kind_t - direction/fill of an iterative shift
//   OPC_*        - the six supported RV32I major opcodes
//   F3_*         - RV32I funct3 encodings for integer ALU ops
//   is_shift_op  - true when opcode/funct3 select SLL/SRL/SRA
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_t;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  function automatic logic is_shift_op(input logic [6:0] opcode, input logic [2:0] funct3);
    return ((opcode == OPC_OP_IMM) || (opcode == OPC_OP)) &&
           ((funct3 == F3_SLL) || (funct3 == F3_SRL));
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response bundle of the ALU sequencer.
//   master modport - requester side (drives request, flush, out_ready)
//   slave modport  - sequencer side (drives in_ready, result, err, busy)
// Handshake: a request transfers on a rising edge where in_valid and
// in_ready are both 1; a result transfers on a rising edge where out_valid
// and out_ready are both 1. valid must not depend on ready, and flush
// cancels both sides of the handshake for that edge.
interface alu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_30;
  logic [XLEN-1:0] data0;
  logic [XLEN-1:0] data1;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            err;
  logic            busy;

  modport master (
    output in_valid, opcode, funct3, funct7_30, data0, data1, flush, out_ready,
    input  in_ready, out_valid, result, err, busy
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7_30, data0, data1, flush, out_ready,
    output in_ready, out_valid, result, err, busy
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU for every non-shift operation,
// plus unsupported-opcode detection.
//   opcode, funct3, funct7_30 - decoded instruction fields
//   data0, data1              - pre-muxed operands
//   result                    - computed value (data0 for shift funct3, so a
//                               zero-distance shift passes the operand through)
//   err                       - opcode is not one of the six supported ones
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_30,
  input  logic [XLEN-1:0] data0,
  input  logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] result,
  output logic            err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (opcode)
      OPC_STORE, OPC_LOAD, OPC_LUI, OPC_AUIPC: result = data0 + data1;
      OPC_OP_IMM, OPC_OP: begin
        case (funct3)
          // Bit 30 of an I-type word is immediate, so SUB only exists for OP.
          F3_ADD:  result = ((opcode == OPC_OP) && funct7_30) ? data0 - data1 : data0 + data1;
          F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(data0) < $signed(data1))};
          F3_SLTU: result = {{(XLEN-1){1'b0}}, (data0 < data1)};
          F3_XOR:  result = data0 ^ data1;
          F3_OR:   result = data0 | data1;
          F3_AND:  result = data0 & data1;
          default: result = data0;
        endcase
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: RV32I integer ALU with a one-bit-per-cycle shifter.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - request/response interface (slave modport)
//   dbg_state  - current FSM state
// Non-shift ops and unsupported opcodes finish in DONE one cycle after
// accept; shifts by N>0 spend N cycles in SHIFT first. DONE holds the
// result until out_ready; flush returns to IDLE from any state.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_sequencer_if.slave bus,
  output state_t dbg_state
);

  state_t               state;
  shift_kind_t          kind;
  shift_kind_t          req_kind;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      result_q;
  logic [XLEN-1:0]      shifted;
  logic [XLEN-1:0]      core_result;
  logic                 core_err;
  logic                 err_q;
  logic                 accept;
  logic                 start_shift;

  alu_core #(.XLEN(XLEN)) u_core (
    .opcode    (bus.opcode),
    .funct3    (bus.funct3),
    .funct7_30 (bus.funct7_30),
    .data0     (bus.data0),
    .data1     (bus.data1),
    .result    (core_result),
    .err       (core_err)
  );

  assign shamt       = bus.data1[SHAMT_W-1:0];
  assign accept      = bus.in_valid & bus.in_ready;
  assign start_shift = is_shift_op(bus.opcode, bus.funct3) && (shamt != '0);
  assign req_kind    = (bus.funct3 == F3_SLL) ? SH_SLL : (bus.funct7_30 ? SH_SRA : SH_SRL);

  always_comb begin
    shifted = result_q;
    case (kind)
      SH_SLL:  shifted = {result_q[XLEN-2:0], 1'b0};
      SH_SRL:  shifted = {1'b0, result_q[XLEN-1:1]};
      SH_SRA:  shifted = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: shifted = result_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      kind     <= SH_SLL;
      cnt      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (bus.flush) begin
      // Result is deliberately kept; only the error flag is cleared.
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              result_q <= bus.data0;
              cnt      <= shamt;
              kind     <= req_kind;
              err_q    <= 1'b0;
              state    <= SHIFT;
            end else begin
              result_q <= core_result;
              cnt      <= '0;
              err_q    <= core_err;
              state    <= DONE;
            end
          end
        end
        SHIFT: begin
          result_q <= shifted;
          cnt      <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !bus.flush;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if #(.XLEN(32)) bus ();
  state_t dbg_state;

  alu_sequencer #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] exp;
    logic [5:0]  lat;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic init_inputs();
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.funct7_30 = 1'b0;
    bus.data0     = '0;
    bus.data1     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Presents one request for one cycle, then scrambles the operand lines.
  // Returns at the falling edge after the accept edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    bus.opcode = op; bus.funct3 = f3; bus.funct7_30 = f7;
    bus.data0 = d0; bus.data1 = d1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.opcode    = 7'($urandom_range(0, 127));
    bus.funct3    = 3'($urandom_range(0, 7));
    bus.funct7_30 = 1'($urandom_range(0, 1));
    bus.data0     = $urandom;
    bus.data1     = $urandom;
  endtask

  // Latency in edges counted from (and including) the accept edge; -1 on timeout.
  task automatic wait_valid(input int limit, output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    init_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'h0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b busy=%b res=%h err=%b expected 0 0 00000000 0",
               bus.out_valid, bus.busy, bus.result, bus.err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b state=%0d expected 1 IDLE", bus.in_ready, dbg_state);
    end
  endtask

  task automatic test_sub();
    int lat;
    issue(OPC_OP, F3_ADD, 1'b1, 32'd5, 32'd7);
    wait_valid(5, lat);
    checks++;
    if (lat !== 1 || bus.result !== 32'hFFFF_FFFE || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL sub: got lat=%0d res=%h err=%b expected 1 fffffffe 0", lat, bus.result, bus.err);
    end
    take();
    checks++;
    if (dbg_state !== IDLE || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_handshake: got state=%0d ov=%b expected IDLE 0", dbg_state, bus.out_valid);
    end
  endtask

  task automatic test_alu_ops();
    vec_t v[13];
    int lat;
    logic [31:0] exp;
    v = '{
      '{OPC_OP_IMM, F3_ADD,  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 6'd1},
      '{OPC_OP,     F3_ADD,  1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 6'd1},
      '{OPC_OP,     F3_ADD,  1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 6'd1},
      '{OPC_OP,     F3_SLT,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 6'd1},
      '{OPC_OP_IMM, F3_SLT,  1'b0, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 6'd1},
      '{OPC_OP,     F3_SLTU, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 6'd1},
      '{OPC_OP_IMM, F3_SLTU, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 6'd1},
      '{OPC_OP,     F3_XOR,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 6'd1},
      '{OPC_OP_IMM, F3_OR,   1'b0, 32'h12340000, 32'h00005678, 32'h12345678, 6'd1},
      '{OPC_OP,     F3_AND,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 6'd1},
      '{OPC_LOAD,   3'b010,  1'b1, 32'h00001000, 32'hFFFFFFFC, 32'h00000FFC, 6'd1},
      '{OPC_STORE,  3'b111,  1'b1, 32'h00000010, 32'h00000020, 32'h00000030, 6'd1},
      '{OPC_AUIPC,  3'b101,  1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 6'd1}
    };
    foreach (v[i]) exp_q.push_back(v[i].exp);
    foreach (v[i]) begin
      issue(v[i].op, v[i].f3, v[i].f7, v[i].d0, v[i].d1);
      wait_valid(5, lat);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== int'(v[i].lat) || bus.result !== exp || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL alu_op[%0d]: got lat=%0d res=%h err=%b expected %0d %h 0",
                 i, lat, bus.result, bus.err, v[i].lat, exp);
      end
      take();
    end
  endtask

  task automatic test_sra_busy();
    issue(OPC_OP_IMM, F3_SRL, 1'b1, 32'h8000_0000, 32'd4);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sra_busy_cycle%0d: got busy=%b ov=%b expected 1 0", k, bus.busy, bus.out_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.result !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra_result: got ov=%b busy=%b res=%h expected 1 1 f8000000",
               bus.out_valid, bus.busy, bus.result);
    end
    take();
  endtask

  task automatic test_shifts();
    vec_t v[5];
    int lat;
    v = '{
      '{OPC_OP,     F3_SRL, 1'b0, 32'h80000000, 32'h00000024, 32'h08000000, 6'd5},
      '{OPC_OP_IMM, F3_SRL, 1'b0, 32'h80000000, 32'h0000001F, 32'h00000001, 6'd32},
      '{OPC_OP,     F3_SLL, 1'b0, 32'h00000001, 32'h0000001F, 32'h80000000, 6'd32},
      '{OPC_OP,     F3_SRL, 1'b1, 32'h40000000, 32'h00000002, 32'h10000000, 6'd3},
      '{OPC_OP,     F3_SLL, 1'b1, 32'hFFFF0000, 32'h00000008, 32'hFF000000, 6'd9}
    };
    foreach (v[i]) begin
      issue(v[i].op, v[i].f3, v[i].f7, v[i].d0, v[i].d1);
      wait_valid(40, lat);
      checks++;
      if (lat !== int'(v[i].lat) || bus.result !== v[i].exp || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL shift[%0d]: got lat=%0d res=%h err=%b expected %0d %h 0",
                 i, lat, bus.result, bus.err, v[i].lat, v[i].exp);
      end
      take();
    end
  endtask

  task automatic test_zero_shift_lui();
    int lat;
    issue(OPC_OP_IMM, F3_SLL, 1'b0, 32'hDEAD_BEEF, 32'd0);
    wait_valid(5, lat);
    checks++;
    if (lat !== 1 || bus.result !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sll_zero: got lat=%0d res=%h expected 1 deadbeef", lat, bus.result);
    end
    take();
    issue(OPC_OP, F3_SRL, 1'b1, 32'h8765_4321, 32'h0000_0020);
    wait_valid(5, lat);
    checks++;
    if (lat !== 1 || bus.result !== 32'h8765_4321) begin
      errors++;
      $display("FAIL sra_zero: got lat=%0d res=%h expected 1 87654321", lat, bus.result);
    end
    take();
    issue(OPC_LUI, 3'b000, 1'b0, 32'd0, 32'h1234_5000);
    wait_valid(5, lat);
    checks++;
    if (lat !== 1 || bus.result !== 32'h1234_5000) begin
      errors++;
      $display("FAIL lui: got lat=%0d res=%h expected 1 12345000", lat, bus.result);
    end
    take();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(OPC_OP, F3_XOR, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
    wait_valid(5, lat);
    bus.opcode = OPC_OP_IMM; bus.funct3 = F3_ADD; bus.funct7_30 = 1'b0;
    bus.data0 = 32'd1; bus.data1 = 32'd1; bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'h5A5A_5A5A) begin
        errors++;
        $display("FAIL backpressure_cycle%0d: got ov=%b in_ready=%b res=%h expected 1 0 5a5a5a5a",
                 k, bus.out_valid, bus.in_ready, bus.result);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (dbg_state !== IDLE || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got state=%0d ov=%b in_ready=%b expected IDLE 0 1",
               dbg_state, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_no_accept: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_flush();
    int lat;
    logic seen_valid;
    issue(OPC_OP, F3_SLL, 1'b0, 32'd1, 32'd31);
    repeat (2) @(negedge clk);
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (dbg_state !== IDLE || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'd4) begin
      errors++;
      $display("FAIL flush_shift: got state=%0d ov=%b busy=%b res=%h expected IDLE 0 0 00000004",
               dbg_state, bus.out_valid, bus.busy, bus.result);
    end
    seen_valid = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_output: got out_valid seen=%b expected 0", seen_valid);
    end
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    bus.opcode = OPC_OP; bus.funct3 = F3_ADD; bus.data0 = 32'd9; bus.data1 = 32'd9;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
    end
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== 32'd4) begin
      errors++;
      $display("FAIL flush_blocks_accept: got busy=%b res=%h expected 0 00000004", bus.busy, bus.result);
    end
    issue(7'b1111111, 3'b000, 1'b0, 32'd123, 32'd456);
    wait_valid(5, lat);
    checks++;
    if (lat !== 1 || bus.err !== 1'b1 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL bad_opcode: got lat=%0d err=%b res=%h expected 1 1 00000000", lat, bus.err, bus.result);
    end
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (bus.err !== 1'b0 || bus.out_valid !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL flush_done: got err=%b ov=%b state=%0d expected 0 0 IDLE", bus.err, bus.out_valid, dbg_state);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    issue(OPC_OP, F3_SRL, 1'b1, 32'h8000_0000, 32'd20);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result !== 32'h0 || bus.err !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL async_reset: got res=%h err=%b ov=%b busy=%b state=%0d expected 0 0 0 0 IDLE",
               bus.result, bus.err, bus.out_valid, bus.busy, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(OPC_OP, F3_AND, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F);
    wait_valid(5, lat);
    checks++;
    if (lat !== 1 || bus.result !== 32'h0F0F_0000) begin
      errors++;
      $display("FAIL after_reset: got lat=%0d res=%h expected 1 0f0f0000", lat, bus.result);
    end
    take();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_sub();
    test_alu_ops();
    test_sra_busy();
    test_shifts();
    test_zero_shift_lui();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
